// File: rtl/frame_flusher.sv
// Streams a rectangular window of the framebuffer to the VGA adapter, one pixel per cycle,
// hiding a fixed MEM_LAT-cycle read latency behind a coordinate pipeline.
module frame_flusher #(
    parameter int SCR_WIDTH  = 160,
    parameter int SCR_HEIGHT = 120,
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter int COLOR_SIZE = 3,
    parameter int ADDR_SIZE  = 15,
    parameter int MEM_LAT    = 1,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic                  in_cont_signal,
    input  logic                  full_mode,
    input  logic [X_BITS-1:0]     win_x0,
    input  logic [X_BITS-1:0]     win_x1,
    input  logic [Y_BITS-1:0]     win_y0,
    input  logic [Y_BITS-1:0]     win_y1,
    output logic [ADDR_SIZE-1:0]  read_addr,
    input  logic [COLOR_SIZE-1:0] read_data,
    output logic [X_BITS-1:0]     pix_x,
    output logic [Y_BITS-1:0]     pix_y,
    output logic [COLOR_SIZE-1:0] pix_color,
    output logic                  plot,
    output logic                  busy,
    output logic                  out_cont_signal,
    input  logic                  next_fin_signal
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic              vld;
        logic [X_BITS-1:0] x;
        logic [Y_BITS-1:0] y;
    } tag_t;

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(SCR_WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(SCR_HEIGHT - 1);

    state_t            state;
    logic [X_BITS-1:0] x0_q, x1_q, cur_x;
    logic [Y_BITS-1:0] y1_q, cur_y;
    logic [1:0]        drain_cnt;
    tag_t              pipe [MEM_LAT];

    logic [X_BITS-1:0] s_x0, s_x1, nxt_x;
    logic [Y_BITS-1:0] s_y0, s_y1, nxt_y;
    logic              s_empty, last_col, last_pix;

    function automatic logic [ADDR_SIZE-1:0] addr_of(input logic [X_BITS-1:0] x,
                                                     input logic [Y_BITS-1:0] y);
        return ADDR_SIZE'(32'(BASE_ADDR) + 32'(x) + 32'(y) * 32'(SCR_WIDTH));
    endfunction

    // Window as it would be latched on a start edge: full screen or clamped window ports.
    always_comb begin
        s_x0 = '0;
        s_x1 = X_LAST;
        s_y0 = '0;
        s_y1 = Y_LAST;
        if (!full_mode) begin
            s_x0 = win_x0;
            s_y0 = win_y0;
            s_x1 = (32'(win_x1) >= 32'(SCR_WIDTH))  ? X_LAST : win_x1;
            s_y1 = (32'(win_y1) >= 32'(SCR_HEIGHT)) ? Y_LAST : win_y1;
        end
        s_empty = (s_x0 > s_x1) || (s_y0 > s_y1);
    end

    always_comb begin
        last_col = (cur_x == x1_q);
        last_pix = last_col && (cur_y == y1_q);
        nxt_x    = last_col ? x0_q : cur_x + 1'b1;
        nxt_y    = last_col ? cur_y + 1'b1 : cur_y;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            out_cont_signal <= 1'b0;
            read_addr       <= '0;
            x0_q            <= '0;
            x1_q            <= '0;
            y1_q            <= '0;
            cur_x           <= '0;
            cur_y           <= '0;
            drain_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_cont_signal) begin
                        x0_q  <= s_x0;
                        x1_q  <= s_x1;
                        y1_q  <= s_y1;
                        cur_x <= s_x0;
                        cur_y <= s_y0;
                        busy  <= 1'b1;
                        if (s_empty) begin
                            state           <= DONE;
                            out_cont_signal <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            read_addr <= addr_of(s_x0, s_y0);
                        end
                    end
                end
                ISSUE: begin
                    if (last_pix) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        cur_x     <= nxt_x;
                        cur_y     <= nxt_y;
                        read_addr <= addr_of(nxt_x, nxt_y);
                    end
                end
                DRAIN: begin
                    // The last read returns in the final drain cycle.
                    if (drain_cnt == 2'(MEM_LAT - 1)) begin
                        state           <= DONE;
                        out_cont_signal <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (next_fin_signal) begin
                        state           <= IDLE;
                        busy            <= 1'b0;
                        out_cont_signal <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the tag pipeline is reset so an aborted flush can never emit a stale plot.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{vld: (state == ISSUE), x: cur_x, y: cur_y};
            for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Colour comes straight from memory so it lines up with the delayed coordinates.
    assign plot      = pipe[MEM_LAT-1].vld;
    assign pix_x     = pipe[MEM_LAT-1].x;
    assign pix_y     = pipe[MEM_LAT-1].y;
    assign pix_color = plot ? read_data : '0;

endmodule

// File: tb/tb_frame_flusher.sv
// Scoreboard bench for frame_flusher on a 4x3 screen with a 3-cycle memory at base address 100.
module tb_frame_flusher;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int XB   = 4;
    localparam int YB   = 2;
    localparam int CS   = 3;
    localparam int AS   = 8;
    localparam int LAT  = 3;
    localparam int BASE = 100;

    logic          Clck = 1'b0;
    logic          Reset = 1'b0;
    logic          in_cont_signal = 1'b0;
    logic          full_mode = 1'b0;
    logic          next_fin_signal = 1'b0;
    logic [XB-1:0] win_x0 = '0, win_x1 = '0;
    logic [YB-1:0] win_y0 = '0, win_y1 = '0;
    logic [AS-1:0] read_addr;
    logic [CS-1:0] read_data;
    logic [XB-1:0] pix_x;
    logic [YB-1:0] pix_y;
    logic [CS-1:0] pix_color;
    logic          plot, busy, out_cont_signal;

    typedef struct {
        int x;
        int y;
        int addr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    frame_flusher #(
        .SCR_WIDTH(W), .SCR_HEIGHT(H), .X_BITS(XB), .Y_BITS(YB),
        .COLOR_SIZE(CS), .ADDR_SIZE(AS), .MEM_LAT(LAT), .BASE_ADDR(BASE)
    ) dut (
        .Clck(Clck), .Reset(Reset), .in_cont_signal(in_cont_signal), .full_mode(full_mode),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .read_addr(read_addr), .read_data(read_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .plot(plot),
        .busy(busy), .out_cont_signal(out_cont_signal), .next_fin_signal(next_fin_signal)
    );

    always #5 Clck = ~Clck;

    // Memory model: data = low address bits, returned LAT cycles after the address.
    logic [AS-1:0] mem_pipe [LAT];
    always @(posedge Clck) begin
        mem_pipe[0] <= read_addr;
        for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign read_data = mem_pipe[LAT-1][CS-1:0];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_plot"}, int'(plot), 0);
        check({tag, "_done"}, int'(out_cont_signal), 0);
    endtask

    // Start a flush and score every plot; abort_at>0 pulses reset right after that plot.
    task automatic run_flush(input int x0, input int x1, input int y0, input int y1,
                             input bit full, input bit noise, input int abort_at);
        int            ex0, ex1, ey0, ey1;
        int            plots = 0;
        int            last_plot = -1;
        int            done_cyc = -1;
        bit            empty;
        exp_t          e;
        logic [AS-1:0] hist [LAT] = '{default: '0};

        ex0 = full ? 0 : x0;
        ey0 = full ? 0 : y0;
        ex1 = full ? W - 1 : ((x1 >= W) ? W - 1 : x1);
        ey1 = full ? H - 1 : ((y1 >= H) ? H - 1 : y1);
        empty = (ex0 > ex1) || (ey0 > ey1);
        sb.delete();
        if (!empty)
            for (int y = ey0; y <= ey1; y++)
                for (int x = ex0; x <= ex1; x++)
                    sb.push_back('{x, y, (BASE + x + y * W) % (1 << AS)});

        @(negedge Clck);
        win_x0 = XB'(x0); win_x1 = XB'(x1);
        win_y0 = YB'(y0); win_y1 = YB'(y1);
        full_mode = full;
        in_cont_signal = 1'b1;

        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge Clck);
            // Inputs after the start edge must not disturb the flush.
            in_cont_signal  = noise && cyc <= 3;
            next_fin_signal = noise && cyc >= 2 && cyc <= 3;
            win_x0 = XB'($urandom); win_x1 = XB'($urandom);
            win_y0 = YB'($urandom); win_y1 = YB'($urandom);
            full_mode = 1'($urandom);

            check("busy", int'(busy), 1);
            if (plot) begin
                if (sb.size() == 0) begin
                    check("extra_plot", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pix_x", int'(pix_x), e.x);
                    check("pix_y", int'(pix_y), e.y);
                    check("pix_color", int'(pix_color), e.addr % (1 << CS));
                    check("read_addr", int'(hist[LAT-1]), e.addr);
                end
                if (last_plot < 0) check("first_plot_cyc", cyc, 1 + LAT);
                else               check("plot_gap", cyc, last_plot + 1);
                last_plot = cyc;
                plots++;
                if (plots == abort_at) begin
                    Reset = 1'b0;
                    #1;
                    check_idle("abort");
                    check("abort_addr", int'(read_addr), 0);
                    check("abort_color", int'(pix_color), 0);
                    @(negedge Clck);
                    Reset = 1'b1;
                    in_cont_signal = 1'b0;
                    repeat (4) begin
                        @(negedge Clck);
                        check_idle("post_abort");
                    end
                    return;
                end
            end
            for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = read_addr;
            if (out_cont_signal) begin
                done_cyc = cyc;
                break;
            end
        end
        in_cont_signal  = 1'b0;
        next_fin_signal = 1'b0;
        check("plots_left", sb.size(), 0);
        check("done_cyc", done_cyc, empty ? 1 : last_plot + 1);
    endtask

    // Hold completion for a while, then acknowledge (optionally with a competing start).
    task automatic finish_done(input int hold, input bit with_start);
        for (int i = 0; i < hold; i++) begin
            @(negedge Clck);
            check("done_hold", int'(out_cont_signal), 1);
        end
        next_fin_signal = 1'b1;
        in_cont_signal  = with_start;
        @(negedge Clck);
        next_fin_signal = 1'b0;
        in_cont_signal  = 1'b0;
        check("ack_done", int'(out_cont_signal), 0);
        check("ack_busy", int'(busy), 0);
        repeat (3) begin
            @(negedge Clck);
            check_idle("after_ack");
        end
    endtask

    initial begin
        repeat (2) @(negedge Clck);
        check_idle("reset");
        check("reset_addr", int'(read_addr), 0);
        check("reset_x", int'(pix_x), 0);
        check("reset_y", int'(pix_y), 0);
        check("reset_color", int'(pix_color), 0);
        Reset = 1'b1;

        run_flush(0, 0, 0, 0, 1'b1, 1'b0, 0);   // full screen, addresses 100..111
        finish_done(10, 1'b1);
        run_flush(1, 2, 1, 2, 1'b0, 1'b1, 0);   // 105,106,109,110 with ignored start/ack noise
        finish_done(0, 1'b0);
        run_flush(3, 1, 0, 2, 1'b0, 1'b0, 0);   // empty in x
        finish_done(2, 1'b0);
        run_flush(0, 3, 2, 1, 1'b0, 1'b0, 0);   // empty in y
        finish_done(1, 1'b0);
        run_flush(2, 9, 0, 1, 1'b0, 1'b0, 0);   // x1 clamped to 3
        finish_done(1, 1'b0);
        run_flush(0, 1, 2, 3, 1'b0, 1'b0, 0);   // y1 clamped to 2
        finish_done(1, 1'b0);
        run_flush(3, 3, 2, 2, 1'b0, 1'b0, 0);   // single bottom-right pixel
        finish_done(1, 1'b0);
        run_flush(0, 0, 0, 0, 1'b1, 1'b0, 5);   // reset at the 5th plot
        run_flush(0, 0, 0, 0, 1'b1, 1'b0, 0);   // restart from (0,0)
        finish_done(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_flusher.md
FRAME_FLUSHER -- requirements
Module: frame_flusher

Interface
REQ-001 Parameter SCR_WIDTH, default 160, pixels per row.
REQ-002 Parameter SCR_HEIGHT, default 120, rows per frame.
REQ-003 Parameter X_BITS, default 8, width of x coordinates.
REQ-004 Parameter Y_BITS, default 7, width of y coordinates.
REQ-005 Parameter COLOR_SIZE, default 3, colour bits per pixel.
REQ-006 Parameter ADDR_SIZE, default 15, framebuffer address width.
REQ-007 Parameter MEM_LAT, default 1, read latency in cycles (1..4).
REQ-008 Parameter BASE_ADDR, default 0, framebuffer start address.
REQ-009 Clck  in  1  the single clock; all state changes on its rising edge.
REQ-010 Reset  in  1  asynchronous, active-low reset.
REQ-011 in_cont_signal  in  1  start request (continuation in).
REQ-012 full_mode  in  1  1 = whole screen; 0 = window given by win_* ports.
REQ-013 win_x0, win_x1  in  X_BITS  inclusive window column bounds.
REQ-014 win_y0, win_y1  in  Y_BITS  inclusive window row bounds.
REQ-015 read_addr  out  ADDR_SIZE  framebuffer read address.
REQ-016 read_data  in  COLOR_SIZE  data for the address issued MEM_LAT cycles earlier.
REQ-017 pix_x, pix_y, pix_color  out  X_BITS/Y_BITS/COLOR_SIZE  pixel to the VGA adapter.
REQ-018 plot  out  1  pix_* valid this cycle.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 out_cont_signal  out  1  flush complete (continuation out).
REQ-021 next_fin_signal  in  1  downstream acknowledges completion.

Function
REQ-022 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-023 IDLE -> ISSUE when in_cont_signal is sampled 1; window bounds latched on the same edge.
REQ-024 When full_mode=1, latched window is (0,0)-(SCR_WIDTH-1,SCR_HEIGHT-1).
REQ-025 win_x1 >= SCR_WIDTH is clamped to SCR_WIDTH-1; win_y1 >= SCR_HEIGHT is clamped to SCR_HEIGHT-1.
REQ-026 After clamping, if x0>x1 or y0>y1, the window is empty: IDLE -> DONE directly, zero plots.
REQ-027 In ISSUE, one address per cycle in row-major order: x from x0 to x1, then y+1 and x reset to x0.
REQ-028 read_addr = BASE_ADDR + x + y*SCR_WIDTH, truncated modulo 2^ADDR_SIZE.
REQ-029 Coordinates travel through a MEM_LAT-deep pipeline; plot=1 with pix_x/pix_y/pix_color=read_data exactly MEM_LAT cycles after the matching address.
REQ-030 Throughput: one plot per cycle, no gaps, for a non-empty window.
REQ-031 The first address is driven in the cycle after the start edge; ISSUE -> DRAIN after issuing (x1,y1).
REQ-032 DRAIN lasts MEM_LAT cycles, then -> DONE; the last plot occurs in the final DRAIN cycle.
REQ-033 Total plots per flush = (x1-x0+1)*(y1-y0+1).
REQ-034 In DONE, out_cont_signal=1 and is held until next_fin_signal is sampled 1, then -> IDLE with out_cont_signal=0.
REQ-035 in_cont_signal is ignored in ISSUE, DRAIN and DONE.
REQ-036 Simultaneous next_fin_signal and in_cont_signal in DONE: go to IDLE only; a new start requires in_cont_signal sampled in IDLE.
REQ-037 next_fin_signal is ignored outside DONE.
REQ-038 win_*/full_mode changes after the start edge do not affect the flush in progress.

Reset
REQ-039 Reset=0 asynchronously forces IDLE and clears plot, busy, out_cont_signal, read_addr, pix_x, pix_y, pix_color and the pipeline.
REQ-040 Reset asserted mid-flush aborts it: no further plots and no completion pulse; restart only via a new start.

Verification
REQ-041 SCR 4x3, MEM_LAT=1, full_mode=1, pulse start -> addresses 0..11 on consecutive cycles, 12 plots (0,0)..(3,2) each one cycle later, then out_cont_signal=1.
REQ-042 SCR 4x3, window (1,1)-(2,2), BASE_ADDR=100 -> addresses 105,106,109,110, 4 plots, then done.
REQ-043 win_x0=3, win_x1=1 -> no plot, out_cont_signal=1 one cycle after start; win_x1=9 on width 4 -> clamped to 3.
REQ-044 MEM_LAT=3, memory model returning addr[2:0] -> each pix_color equals the address issued 3 cycles earlier; done follows the last plot.
REQ-045 Reset pulsed at the 5th plot -> plot=0 immediately, busy=0, no out_cont_signal; a new start flushes from (x0,y0).
REQ-046 Hold next_fin_signal=0 for 10 cycles in DONE -> out_cont_signal stays 1; assert it together with in_cont_signal -> IDLE, no new flush begins.
